cpu_mem_ctrl_subsys: RTL and testbench
======================================

Name: cpu_mem_ctrl_subsys

Overview:
Memory-and-control subsystem beside the pipelined CPU. It holds two RAMs: a 256x16 instruction memory and a 256x16 data memory. It also holds a control sequencer that runs a fixed-length PLL-settle wait and an ADC measurement sequence, each started and reported through single-bit level handshakes. The CPU reaches the sequencer through its IO control and status bits.

Parameters:
ADDR_W, 8, address width of both RAMs (depth 2^ADDR_W)
DATA_W, 16, word width of both RAMs
PLL_WAIT_CYCLES, 2000, clk cycles from PLL-wait start to pll_done
ADC_RST_CYCLES, 4, clk cycles rstn_adc and clrn are held low at measurement start
ADC_CLK_DIV, 16, clk cycles per clk_adc period (even, at least 2)
ADC_CLK_PULSES, 56, clk_adc periods per measurement (4 + 56*16 = 900 cycles total)

Ports:
clk  in  1  single clock; all state changes on the rising edge
rst  in  1  synchronous reset, active-high
i_addr  in  ADDR_W  instruction read/write address
i_we  in  1  instruction write enable
i_wdata  in  DATA_W  instruction write data
i_rdata  out  DATA_W  instruction read data
d_addr  in  ADDR_W  data read/write address
d_we  in  1  data write enable
d_wdata  in  DATA_W  data write data
d_rdata  out  DATA_W  data read data
pll_start  in  1  level request for the PLL wait
meas_start  in  1  level request for an ADC measurement
pll_done  out  1  PLL wait complete
meas_done  out  1  measurement complete
rstn_adc  out  1  ADC reset, active-low
clk_adc  out  1  ADC conversion clock
clrn  out  1  ADC counter clear, active-low

Behaviour:
- RAMs:
  - Read is combinational: rdata = mem[addr], so read latency is 0.
  - Write happens on the clk edge when we=1. Read-during-write to the same address returns the old word until the edge.
- rst does not touch RAM contents. Contents preloaded by the bench before reset must survive reset. Uninitialised words read X.
- No address wrap logic is needed; the full 8-bit space is valid.
- rst=1 forces both sequencers to IDLE with pll_done=0, meas_done=0, rstn_adc=1, clrn=1, clk_adc=0, and counters cleared.
- PLL sequencer, states IDLE, WAIT, DONE:
  - IDLE goes to WAIT when pll_start=1, and the counter loads 0.
  - WAIT increments the counter each cycle. It goes to DONE when the counter reaches PLL_WAIT_CYCLES-1, so pll_done rises exactly PLL_WAIT_CYCLES cycles after the first cycle pll_start is sampled high.
  - DONE holds pll_done=1 while pll_start stays 1.
  - pll_start=0 in any state returns to IDLE on the next edge and clears pll_done. Deasserting during WAIT aborts; a re-assert restarts from 0.
- Measurement sequencer, states IDLE, RST, CONV, DONE; it runs independently of the PLL sequencer, and both may run at once:
  - IDLE goes to RST when meas_start=1.
  - RST holds rstn_adc=0 and clrn=0 for ADC_RST_CYCLES cycles, then goes to CONV.
  - CONV drives rstn_adc=1 and clrn=1. clk_adc is low for the first ADC_CLK_DIV/2 cycles of each period and high for the second half. After ADC_CLK_PULSES full periods it goes to DONE with clk_adc=0.
  - DONE holds meas_done=1 while meas_start=1.
  - meas_start=0 in any state returns to IDLE next edge with idle output values. meas_done rises 900 cycles after start with the default parameters.
- All sequencer outputs are registered, so there are no combinational paths from start inputs to outputs.
- rst mid-sequence aborts immediately to the reset values.

Decomposition:
- Shared package holds ADDR_W, DATA_W, the default cycle constants, and the sequencer state enums.
- One natural sub-module, sp_ram, is a single-port 256x16 RAM with combinational read and synchronous write, instantiated twice.
- The sequencers stay in the top level.

Test Plan:
1. Preload I mem[0]=16'h1234 and D mem[0]=16'h00AB, then pulse rst. i_addr=0 must read 16'h1234 and d_addr=0 must read 16'h00AB after reset.
2. Write d_addr=2, d_wdata=16'h3C00, d_we=1 for one edge. d_rdata=16'h3C00 from the same cycle after the edge; d_addr=1 must be unchanged.
3. Hold pll_start=1 from cycle 0. pll_done must be 0 at cycle 1999 and 1 at cycle 2000, and stay 1; drop pll_start and pll_done must be 0 one cycle later.
4. Hold meas_start=1. rstn_adc and clrn must be low for cycles 1-4. Exactly 56 clk_adc rising edges must occur, each 16 cycles apart. meas_done must be 1 at cycle 900 with clk_adc=0.
5. Assert pll_start and meas_start together. meas_done must rise at 900 and pll_done at 2000, independently.
6. Assert rst during CONV at cycle 300. Next cycle all outputs must take reset values; re-asserting meas_start must restart a full 900-cycle sequence.

Source files
------------

// File: rtl/cpu_mem_ctrl_subsys_pkg.sv
// Shared widths, default sequencer timing and state encodings for the
// CPU memory-and-control subsystem.
package cpu_mem_ctrl_subsys_pkg;

    localparam int DEFAULT_ADDR_W          = 8;
    localparam int DEFAULT_DATA_W          = 16;
    localparam int DEFAULT_PLL_WAIT_CYCLES = 2000;
    localparam int DEFAULT_ADC_RST_CYCLES  = 4;
    localparam int DEFAULT_ADC_CLK_DIV     = 16;
    localparam int DEFAULT_ADC_CLK_PULSES  = 56;

    typedef enum logic [1:0] {
        PLL_IDLE,
        PLL_WAIT,
        PLL_DONE
    } pll_state_t;

    typedef enum logic [1:0] {
        MEAS_IDLE,
        MEAS_RST,
        MEAS_CONV,
        MEAS_DONE
    } meas_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cpu_mem_ctrl_subsys_sp_ram.sv
// Single-port RAM: combinational read, write on the rising clk edge.
module sp_ram
    import cpu_mem_ctrl_subsys_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the array has no reset branch on purpose; contents loaded before
    // rst must survive it, and a reset loop would turn the RAM into flops.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read-during-write sees the old word until the edge commits the write.
    assign rdata = mem[addr];

endmodule

// File: rtl/cpu_mem_ctrl_subsys.sv
// Instruction/data RAMs plus the PLL-settle and ADC measurement sequencers,
// each driven by a level start request and reporting through registered outputs.
module cpu_mem_ctrl_subsys
    import cpu_mem_ctrl_subsys_pkg::*;
#(
    parameter int ADDR_W          = DEFAULT_ADDR_W,
    parameter int DATA_W          = DEFAULT_DATA_W,
    parameter int PLL_WAIT_CYCLES = DEFAULT_PLL_WAIT_CYCLES,
    parameter int ADC_RST_CYCLES  = DEFAULT_ADC_RST_CYCLES,
    parameter int ADC_CLK_DIV     = DEFAULT_ADC_CLK_DIV,
    parameter int ADC_CLK_PULSES  = DEFAULT_ADC_CLK_PULSES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              pll_start,
    input  logic              meas_start,
    output logic              pll_done,
    output logic              meas_done,
    output logic              rstn_adc,
    output logic              clk_adc,
    output logic              clrn
);

    localparam int PLL_CNT_W   = $clog2(PLL_WAIT_CYCLES + 1);
    localparam int MEAS_CNT_W  = $clog2(max2(ADC_CLK_DIV, ADC_RST_CYCLES) + 1);
    localparam int PULSE_CNT_W = $clog2(ADC_CLK_PULSES + 1);

    localparam logic [PLL_CNT_W-1:0]   PLL_LAST   = PLL_CNT_W'(PLL_WAIT_CYCLES - 1);
    localparam logic [MEAS_CNT_W-1:0]  RST_LAST   = MEAS_CNT_W'(ADC_RST_CYCLES - 1);
    localparam logic [MEAS_CNT_W-1:0]  DIV_LAST   = MEAS_CNT_W'(ADC_CLK_DIV - 1);
    localparam logic [MEAS_CNT_W-1:0]  DIV_PENULT = MEAS_CNT_W'(ADC_CLK_DIV - 2);
    localparam logic [MEAS_CNT_W-1:0]  DIV_HALF   = MEAS_CNT_W'(ADC_CLK_DIV / 2);
    localparam logic [PULSE_CNT_W-1:0] PULSE_LAST = PULSE_CNT_W'(ADC_CLK_PULSES - 1);

    sp_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_imem (
        .clk   (clk),
        .addr  (i_addr),
        .we    (i_we),
        .wdata (i_wdata),
        .rdata (i_rdata)
    );

    sp_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dmem (
        .clk   (clk),
        .addr  (d_addr),
        .we    (d_we),
        .wdata (d_wdata),
        .rdata (d_rdata)
    );

    pll_state_t             pll_state, pll_state_next;
    logic [PLL_CNT_W-1:0]   pll_cnt, pll_cnt_next;
    logic                   pll_done_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            pll_state <= PLL_IDLE;
            pll_cnt   <= '0;
            pll_done  <= 1'b0;
        end else begin
            pll_state <= pll_state_next;
            pll_cnt   <= pll_cnt_next;
            pll_done  <= pll_done_next;
        end
    end

    // NOTE: every always_comb output gets a default before any branch, and
    // uses blocking '=', so no path leaves a value held and no latch appears.
    always_comb begin
        pll_state_next = pll_state;
        pll_cnt_next   = pll_cnt;
        if (!pll_start) begin
            pll_state_next = PLL_IDLE;
            pll_cnt_next   = '0;
        end else begin
            unique case (pll_state)
                PLL_IDLE: begin
                    pll_state_next = PLL_WAIT;
                    pll_cnt_next   = '0;
                end
                PLL_WAIT: begin
                    // DONE is entered on the same edge the count reaches its last value.
                    pll_cnt_next = pll_cnt + 1'b1;
                    if (pll_cnt_next == PLL_LAST) begin
                        pll_state_next = PLL_DONE;
                    end
                end
                PLL_DONE: ;
                default:  pll_state_next = PLL_IDLE;
            endcase
        end
        pll_done_next = (pll_state_next == PLL_DONE);
    end

    meas_state_t            meas_state, meas_state_next;
    logic [MEAS_CNT_W-1:0]  meas_cnt, meas_cnt_next;
    logic [PULSE_CNT_W-1:0] pulse_cnt, pulse_cnt_next;
    logic                   meas_done_next, rstn_adc_next, clrn_next, clk_adc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            meas_state <= MEAS_IDLE;
            meas_cnt   <= '0;
            pulse_cnt  <= '0;
            meas_done  <= 1'b0;
            rstn_adc   <= 1'b1;
            clrn       <= 1'b1;
            clk_adc    <= 1'b0;
        end else begin
            meas_state <= meas_state_next;
            meas_cnt   <= meas_cnt_next;
            pulse_cnt  <= pulse_cnt_next;
            meas_done  <= meas_done_next;
            rstn_adc   <= rstn_adc_next;
            clrn       <= clrn_next;
            clk_adc    <= clk_adc_next;
        end
    end

    // meas_cnt counts the ADC reset cycles in RST and the clk_adc phase in CONV.
    always_comb begin
        meas_state_next = meas_state;
        meas_cnt_next   = meas_cnt;
        pulse_cnt_next  = pulse_cnt;
        if (!meas_start) begin
            meas_state_next = MEAS_IDLE;
            meas_cnt_next   = '0;
            pulse_cnt_next  = '0;
        end else begin
            unique case (meas_state)
                MEAS_IDLE: begin
                    meas_state_next = MEAS_RST;
                    meas_cnt_next   = '0;
                end
                MEAS_RST: begin
                    if (meas_cnt == RST_LAST) begin
                        meas_state_next = MEAS_CONV;
                        meas_cnt_next   = '0;
                        pulse_cnt_next  = '0;
                    end else begin
                        meas_cnt_next = meas_cnt + 1'b1;
                    end
                end
                MEAS_CONV: begin
                    // The DONE cycle takes the slot of the last high phase cycle,
                    // so meas_done lands on start + RST + PULSES*DIV with clk_adc low.
                    if (pulse_cnt == PULSE_LAST && meas_cnt == DIV_PENULT) begin
                        meas_state_next = MEAS_DONE;
                    end else if (meas_cnt == DIV_LAST) begin
                        meas_cnt_next  = '0;
                        pulse_cnt_next = pulse_cnt + 1'b1;
                    end else begin
                        meas_cnt_next = meas_cnt + 1'b1;
                    end
                end
                MEAS_DONE: ;
                default:   meas_state_next = MEAS_IDLE;
            endcase
        end
        rstn_adc_next  = (meas_state_next != MEAS_RST);
        clrn_next      = (meas_state_next != MEAS_RST);
        clk_adc_next   = (meas_state_next == MEAS_CONV) && (meas_cnt_next >= DIV_HALF);
        meas_done_next = (meas_state_next == MEAS_DONE);
    end

endmodule

// File: tb/tb_cpu_mem_ctrl_subsys.sv
// Scoreboard bench for cpu_mem_ctrl_subsys: expectations are queued with the
// cycle they apply to and popped as the run reaches that cycle.
module tb_cpu_mem_ctrl_subsys;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] i_addr;
    logic              i_we;
    logic [DATA_W-1:0] i_wdata;
    logic [DATA_W-1:0] i_rdata;
    logic [ADDR_W-1:0] d_addr;
    logic              d_we;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              pll_start;
    logic              meas_start;
    logic              pll_done;
    logic              meas_done;
    logic              rstn_adc;
    logic              clk_adc;
    logic              clrn;

    cpu_mem_ctrl_subsys #(
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W),
        .PLL_WAIT_CYCLES (2000),
        .ADC_RST_CYCLES  (4),
        .ADC_CLK_DIV     (16),
        .ADC_CLK_PULSES  (56)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_addr     (i_addr),
        .i_we       (i_we),
        .i_wdata    (i_wdata),
        .i_rdata    (i_rdata),
        .d_addr     (d_addr),
        .d_we       (d_we),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .pll_start  (pll_start),
        .meas_start (meas_start),
        .pll_done   (pll_done),
        .meas_done  (meas_done),
        .rstn_adc   (rstn_adc),
        .clk_adc    (clk_adc),
        .clrn       (clrn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       sig;
        logic [15:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   cyc;
    int   tests_run;
    int   tests_failed;

    function automatic logic [15:0] sig_val(input string s);
        case (s)
            "pll_done":  sig_val = {15'b0, pll_done};
            "meas_done": sig_val = {15'b0, meas_done};
            "rstn_adc":  sig_val = {15'b0, rstn_adc};
            "clrn":      sig_val = {15'b0, clrn};
            "clk_adc":   sig_val = {15'b0, clk_adc};
            "i_rdata":   sig_val = i_rdata;
            "d_rdata":   sig_val = d_rdata;
            default:     sig_val = 'x;
        endcase
    endfunction

    task automatic expect_at(input int c, input string s, input logic [15:0] v);
        exp_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic score();
        exp_t        e;
        logic [15:0] obs;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e   = sb_q.pop_front();
            obs = sig_val(e.sig);
            tests_run++;
            if (e.cyc != cyc || obs !== e.val) begin
                tests_failed++;
                $display("FAIL %s@%0d: got %h at cycle %0d, expected %h", e.sig, e.cyc, obs, cyc, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        score();
    endtask

    task automatic flush(input string tag);
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            tests_run++;
            tests_failed++;
            $display("FAIL %s unchecked %s@%0d: got nothing, expected %h", tag, e.sig, e.cyc, e.val);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        // Preload through the write ports; reset must leave these words alone.
        i_addr = 8'h00; i_wdata = 16'h1234; i_we = 1'b1;
        d_addr = 8'h00; d_wdata = 16'h00AB; d_we = 1'b1;
        step();
        i_we   = 1'b0;
        d_addr = 8'h01; d_wdata = 16'h5555;
        step();
        d_addr = 8'h02; d_wdata = 16'h1111;
        step();
        d_we = 1'b0;
        // Put the measurement in RST so the reset pulse has outputs to restore.
        meas_start = 1'b1;
        step();
        step();
        expect_at(cyc, "rstn_adc", 16'h0);
        score();
        rst = 1'b1;
        step();
        expect_at(cyc, "rstn_adc", 16'h1);
        expect_at(cyc, "clrn", 16'h1);
        expect_at(cyc, "clk_adc", 16'h0);
        expect_at(cyc, "pll_done", 16'h0);
        expect_at(cyc, "meas_done", 16'h0);
        score();
        meas_start = 1'b0;
        rst        = 1'b0;
        step();
        i_addr = 8'h00;
        d_addr = 8'h00;
        #1;
        expect_at(cyc, "i_rdata", 16'h1234);
        expect_at(cyc, "d_rdata", 16'h00AB);
        score();
        flush("reset");
    endtask

    task automatic test_ram_write();
        d_addr = 8'h02; d_wdata = 16'h3C00; d_we = 1'b1;
        #1;
        expect_at(cyc, "d_rdata", 16'h1111);
        score();
        step();
        d_we = 1'b0;
        expect_at(cyc, "d_rdata", 16'h3C00);
        score();
        d_addr = 8'h01;
        #1;
        expect_at(cyc, "d_rdata", 16'h5555);
        score();
        // Top address, both RAMs written with different words at once.
        i_addr = 8'hFF; i_wdata = 16'hBEEF; i_we = 1'b1;
        d_addr = 8'hFF; d_wdata = 16'h0F0F; d_we = 1'b1;
        step();
        i_we = 1'b0;
        d_we = 1'b0;
        expect_at(cyc, "i_rdata", 16'hBEEF);
        expect_at(cyc, "d_rdata", 16'h0F0F);
        score();
        i_addr = 8'h00;
        #1;
        expect_at(cyc, "i_rdata", 16'h1234);
        score();
        flush("ram_write");
    endtask

    task automatic test_pll();
        cyc       = 0;
        pll_start = 1'b1;
        expect_at(1, "pll_done", 16'h0);
        expect_at(1999, "pll_done", 16'h0);
        expect_at(2000, "pll_done", 16'h1);
        expect_at(2004, "pll_done", 16'h1);
        expect_at(2005, "pll_done", 16'h0);
        repeat (2004) step();
        pll_start = 1'b0;
        step();
        // Abort mid-wait, then a fresh request must count from zero again.
        cyc       = 0;
        pll_start = 1'b1;
        expect_at(500, "pll_done", 16'h0);
        expect_at(501, "pll_done", 16'h0);
        repeat (500) step();
        pll_start = 1'b0;
        step();
        cyc       = 0;
        pll_start = 1'b1;
        expect_at(1999, "pll_done", 16'h0);
        expect_at(2000, "pll_done", 16'h1);
        repeat (2000) step();
        pll_start = 1'b0;
        step();
        flush("pll");
    endtask

    task automatic test_meas();
        logic prev_clk;
        int   rises;
        int   bad_gaps;
        int   last_rise;
        cyc        = 0;
        meas_start = 1'b1;
        expect_at(1, "rstn_adc", 16'h0);
        expect_at(1, "clrn", 16'h0);
        expect_at(4, "rstn_adc", 16'h0);
        expect_at(4, "clrn", 16'h0);
        expect_at(5, "rstn_adc", 16'h1);
        expect_at(5, "clrn", 16'h1);
        expect_at(5, "clk_adc", 16'h0);
        expect_at(12, "clk_adc", 16'h0);
        expect_at(13, "clk_adc", 16'h1);
        expect_at(899, "clk_adc", 16'h1);
        expect_at(899, "meas_done", 16'h0);
        expect_at(900, "meas_done", 16'h1);
        expect_at(900, "clk_adc", 16'h0);
        expect_at(905, "meas_done", 16'h1);
        expect_at(906, "meas_done", 16'h0);
        expect_at(906, "rstn_adc", 16'h1);
        prev_clk  = clk_adc;
        rises     = 0;
        bad_gaps  = 0;
        last_rise = 0;
        for (int i = 0; i < 905; i++) begin
            step();
            if (clk_adc === 1'b1 && prev_clk === 1'b0) begin
                if (rises > 0 && cyc - last_rise != 16) bad_gaps++;
                rises++;
                last_rise = cyc;
            end
            prev_clk = clk_adc;
        end
        tests_run++;
        if (rises !== 56) begin
            tests_failed++;
            $display("FAIL clk_adc_rises: got %0d, expected 56", rises);
        end
        tests_run++;
        if (bad_gaps !== 0) begin
            tests_failed++;
            $display("FAIL clk_adc_period: got %0d gaps not 16 cycles, expected 0", bad_gaps);
        end
        meas_start = 1'b0;
        step();
        flush("meas");
    endtask

    task automatic test_concurrent();
        cyc        = 0;
        pll_start  = 1'b1;
        meas_start = 1'b1;
        expect_at(899, "meas_done", 16'h0);
        expect_at(900, "meas_done", 16'h1);
        expect_at(900, "pll_done", 16'h0);
        expect_at(1999, "pll_done", 16'h0);
        expect_at(2000, "pll_done", 16'h1);
        expect_at(2000, "meas_done", 16'h1);
        expect_at(2001, "pll_done", 16'h0);
        expect_at(2001, "meas_done", 16'h0);
        repeat (2000) step();
        pll_start  = 1'b0;
        meas_start = 1'b0;
        step();
        flush("concurrent");
    endtask

    task automatic test_reset_mid();
        // Cycle 304 sits in the high half of a clk_adc period.
        cyc        = 0;
        pll_start  = 1'b1;
        meas_start = 1'b1;
        expect_at(304, "clk_adc", 16'h1);
        expect_at(305, "rstn_adc", 16'h1);
        expect_at(305, "clrn", 16'h1);
        expect_at(305, "clk_adc", 16'h0);
        expect_at(305, "meas_done", 16'h0);
        expect_at(305, "pll_done", 16'h0);
        repeat (304) step();
        rst = 1'b1;
        step();
        rst        = 1'b0;
        pll_start  = 1'b0;
        meas_start = 1'b0;
        step();
        flush("reset_mid");
        cyc        = 0;
        meas_start = 1'b1;
        expect_at(1, "rstn_adc", 16'h0);
        expect_at(5, "rstn_adc", 16'h1);
        expect_at(899, "meas_done", 16'h0);
        expect_at(900, "meas_done", 16'h1);
        expect_at(900, "clk_adc", 16'h0);
        repeat (900) step();
        meas_start = 1'b0;
        step();
        flush("restart");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        rst          = 1'b1;
        i_addr       = '0;
        i_we         = 1'b0;
        i_wdata      = '0;
        d_addr       = '0;
        d_we         = 1'b0;
        d_wdata      = '0;
        pll_start    = 1'b0;
        meas_start   = 1'b0;

        test_reset();
        test_ram_write();
        test_pll();
        test_meas();
        test_concurrent();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
